shift_arbiter: RTL

Sequencer/arbiter sharing one 8-bit barrel shifter between two requesters. Accepts a shift job (data, 4-bit amount, direction) from either requester under round-robin priority. Executes amounts up to 15 as successive passes of at most 7 through the shifter. Returns the registered result with a one-cycle completion pulse. Sits in front of the existing combinational `shift` block; clients never drive the shifter directly.

---
 rtl/shift_arb_pkg.sv | 22 ++
 rtl/shift.sv | 17 +
 rtl/shift_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter and its shifter.
package shift_arb_pkg;

   localparam int DW       = 8;   // data width, fixed by the shifter
   localparam int AW       = 4;   // total shift amount width (0..15)
   localparam int PASS_MAX = 7;   // largest amount the shifter applies in one pass

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Amount applied in the next pass: whatever remains, capped at one pass.
   function automatic logic [AW-1:0] pass_step(input logic [AW-1:0] rem);
      if (rem > AW'(PASS_MAX)) begin
         return AW'(PASS_MAX);
      end
      return rem;
   endfunction

endpackage

// File: rtl/shift.sv
// Existing combinational barrel shifter: logical, zero fill, c=0 left, c=1 right.
module shift #(
   parameter int W  = 8,
   parameter int SW = 3
) (
   input  logic [W-1:0]  d,
   input  logic [SW-1:0] s,
   input  logic          c,
   output logic [W-1:0]  out
);

   // Single-stage shift in the selected direction.
   always_comb begin
      out = c ? (d >> s) : (d << s);
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one barrel shifter between two requesters.
// Long shifts are split into passes of at most PASS_MAX through the shifter.
module shift_arbiter #(
   parameter int DW       = shift_arb_pkg::DW,
   parameter int AW       = shift_arb_pkg::AW,
   parameter int PASS_MAX = shift_arb_pkg::PASS_MAX
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   input  logic [AW-1:0] amt0,
   input  logic [AW-1:0] amt1,
   input  logic          dir0,
   input  logic          dir1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          busy,
   output logic          done,
   output logic          done_id,
   output logic [DW-1:0] dout
);

   import shift_arb_pkg::*;

   // Select width of the shifter, derived from the per-pass limit.
   localparam int SW = $clog2(PASS_MAX + 1);

   state_t        state_q, state_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [AW-1:0] rem_q, rem_d;
   logic          dir_q, dir_d;
   logic          id_q, id_d;
   logic          prio_q, prio_d;
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          done_id_q, done_id_d;
   logic [DW-1:0] dout_q, dout_d;

   logic [AW-1:0] step;
   logic [AW-1:0] rem_after;
   logic [DW-1:0] shift_out;
   logic          any_req;
   logic          winner;

   // Round-robin choice: prio wins a tie, otherwise the lone requester wins.
   always_comb begin
      any_req = req0 | req1;
      winner  = (req0 & req1) ? prio_q : req1;
   end

   // Amount for the current pass and what is left after it.
   always_comb begin
      step      = pass_step(rem_q);
      rem_after = rem_q - step;
   end

   shift #(
      .W  (DW),
      .SW (SW)
   ) u_shift (
      .d   (acc_q),
      .s   (step[SW-1:0]),
      .c   (dir_q),
      .out (shift_out)
   );

   // Sequencer: capture in IDLE, one pass per SHIFT cycle, publish on entry to DONE.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      dir_d     = dir_q;
      id_d      = id_q;
      prio_d    = prio_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done_id_d = done_id_q;
      dout_d    = dout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               acc_d   = winner ? din1 : din0;
               rem_d   = winner ? amt1 : amt0;
               dir_d   = winner ? dir1 : dir0;
               id_d    = winner;
               prio_d  = ~winner;
               gnt0_d  = ~winner;
               gnt1_d  = winner;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            acc_d = shift_out;
            rem_d = rem_after;
            if (rem_after == '0) begin
               dout_d    = shift_out;
               done_id_d = id_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         rem_q     <= '0;
         dir_q     <= 1'b0;
         id_q      <= 1'b0;
         prio_q    <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done_id_q <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         dir_q     <= dir_d;
         id_q      <= id_d;
         prio_q    <= prio_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done_id_q <= done_id_d;
         dout_q    <= dout_d;
      end
   end

   // Outputs come straight from registered state.
   always_comb begin
      gnt0    = gnt0_q;
      gnt1    = gnt1_q;
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_DONE);
      done_id = done_id_q;
      dout    = dout_q;
   end

endmodule
